// File: rtl/keccak_cust5_pkg.sv
// Shared definitions for the l.cust5 Keccak sequencer.
// Contents: the l.cust5 major opcode, the five sub-op encodings carried in
// insn[4:0], and the sequencer state enumeration.
package keccak_cust5_pkg;

  localparam logic [5:0] CUST5_OPCODE = 6'h3C;

  localparam logic [4:0] OP_RESET  = 5'b00000;
  localparam logic [4:0] OP_START  = 5'b00100;
  localparam logic [4:0] OP_MIDDLE = 5'b00010;
  localparam logic [4:0] OP_END    = 5'b00001;
  localparam logic [4:0] OP_STORE  = 5'b01000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ABSORB   = 2'd1,
    ST_WAIT_OUT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/keccak_lane_mux.sv
// Registered digest lane selector used by the store sub-op.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en_i             an accepted store this cycle
//   zero_i           force a zero result (store outside the DONE state)
//   lane_i           6-bit lane index from limm; indices >= OUT_WORDS read as 0
//   digest_i         latched digest, lane i = digest_i[32*i +: 32]
//   result_o         registered lane value
//   result_valid_o   high for one cycle after each accepted store
module keccak_lane_mux #(
  parameter int OUT_WORDS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic                      zero_i,
  input  logic [5:0]                lane_i,
  input  logic [32*OUT_WORDS-1:0]   digest_i,
  output logic [31:0]               result_o,
  output logic                      result_valid_o
);

  localparam int         LW       = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam logic [6:0] LANE_LIM = 7'(OUT_WORDS);

  logic        lane_oob;
  logic [31:0] sel_d;
  logic [31:0] result_q;
  logic        result_valid_q;

  assign lane_oob = ({1'b0, lane_i} >= LANE_LIM);
  assign sel_d    = (zero_i || lane_oob) ? 32'd0 : digest_i[32*lane_i[LW-1:0] +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q       <= 32'd0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= en_i;
      if (en_i) begin
        result_q <= sel_d;
      end
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;

endmodule

// File: rtl/keccak_cust5_sequencer.sv
// EX-stage sequencer that drives a Keccak core for l.cust5 instructions.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   insn_valid, ex_freeze      EX holds an l.cust5 / EX is frozen this cycle
//   cust5_op, cust5_limm, opa  sub-op, store lane index, absorb word (rA)
//   kc_in, kc_in_valid,
//   kc_is_last, kc_reset       registered write/reset strobes to the core
//   kc_buffer_full             core cannot take a word this cycle
//   kc_out_ready, kc_out       digest handshake from the core
//   result, result_valid       registered store result to the WB mux
//   stall                      freeze request for IF/ID/EX
//   err                        sticky protocol / timeout error
module keccak_cust5_sequencer
  import keccak_cust5_pkg::*;
#(
  parameter int RATE_WORDS = 34,
  parameter int OUT_WORDS  = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     insn_valid,
  input  logic                     ex_freeze,
  input  logic [4:0]               cust5_op,
  input  logic [5:0]               cust5_limm,
  input  logic [31:0]              opa,
  output logic [31:0]              kc_in,
  output logic                     kc_in_valid,
  output logic                     kc_is_last,
  output logic                     kc_reset,
  input  logic                     kc_buffer_full,
  input  logic                     kc_out_ready,
  input  logic [32*OUT_WORDS-1:0]  kc_out,
  output logic [31:0]              result,
  output logic                     result_valid,
  output logic                     stall,
  output logic                     err
);

  localparam int             CW           = $clog2(RATE_WORDS + 1);
  localparam int             TW           = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  RATE_LAST    = CW'(RATE_WORDS - 1);
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [6:0]     LANE_LIM     = 7'(OUT_WORDS);

  state_e                   state_q;
  logic [CW-1:0]            word_cnt_q;
  logic [CW-1:0]            word_cnt_d;
  logic [TW-1:0]            timer_q;
  logic [32*OUT_WORDS-1:0]  digest_q;
  logic                     err_q;
  logic [31:0]              kc_in_q;
  logic                     kc_in_valid_q;
  logic                     kc_is_last_q;
  logic                     kc_reset_q;

  logic idle_or_done;
  logic write_legal;
  logic wait_block;
  logic accept;
  logic lane_oob;
  logic store_en;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);

  // Sub-ops that will actually push a word into the core this cycle; only
  // these wait on kc_buffer_full.
  assign write_legal = ((cust5_op == OP_START)  && idle_or_done) ||
                       ((cust5_op == OP_MIDDLE) && (state_q == ST_ABSORB)) ||
                       ((cust5_op == OP_END)    && (state_q != ST_WAIT_OUT));

  // While the permutation runs, any write or store is held in EX until the
  // digest lands, so a store coinciding with kc_out_ready reads the new digest.
  assign wait_block = (state_q == ST_WAIT_OUT) &&
                      ((cust5_op == OP_START) || (cust5_op == OP_MIDDLE) ||
                       (cust5_op == OP_END)   || (cust5_op == OP_STORE));

  // The reset sub-op is never stalled so it always wins.
  assign stall    = insn_valid && (cust5_op != OP_RESET) &&
                    (wait_block || (write_legal && kc_buffer_full));
  assign accept   = insn_valid && !ex_freeze && !stall;
  assign lane_oob = ({1'b0, cust5_limm} >= LANE_LIM);
  assign store_en = accept && (cust5_op == OP_STORE);

  // The core flushes itself at a full rate block; the count just wraps.
  assign word_cnt_d = (word_cnt_q == RATE_LAST) ? '0 : word_cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      word_cnt_q    <= '0;
      timer_q       <= '0;
      digest_q      <= '0;
      err_q         <= 1'b0;
      kc_in_q       <= 32'd0;
      kc_in_valid_q <= 1'b0;
      kc_is_last_q  <= 1'b0;
      kc_reset_q    <= 1'b1;
    end else begin
      kc_in_valid_q <= 1'b0;
      kc_is_last_q  <= 1'b0;
      kc_reset_q    <= 1'b0;

      if (state_q == ST_WAIT_OUT) begin
        timer_q <= timer_q + TW'(1);
        if (kc_out_ready) begin
          digest_q <= kc_out;
          state_q  <= ST_DONE;
        end else if (timer_q == TIMEOUT_LAST) begin
          err_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      end

      // Placed after the WAIT_OUT update so a reset sub-op overrides it.
      if (accept) begin
        case (cust5_op)
          OP_RESET: begin
            kc_reset_q <= 1'b1;
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            timer_q    <= '0;
            digest_q   <= '0;
            err_q      <= 1'b0;
          end
          OP_START: begin
            if (idle_or_done) begin
              // Core applies the reset before the write in the same cycle.
              kc_reset_q    <= 1'b1;
              kc_in_q       <= opa;
              kc_in_valid_q <= 1'b1;
              word_cnt_q    <= CW'(1);
              state_q       <= ST_ABSORB;
            end else begin
              err_q <= 1'b1;
            end
          end
          OP_MIDDLE: begin
            if (state_q == ST_ABSORB) begin
              kc_in_q       <= opa;
              kc_in_valid_q <= 1'b1;
              word_cnt_q    <= word_cnt_d;
            end else begin
              err_q <= 1'b1;
            end
          end
          OP_END: begin
            if (state_q == ST_ABSORB) begin
              kc_in_q       <= opa;
              kc_in_valid_q <= 1'b1;
              kc_is_last_q  <= 1'b1;
              word_cnt_q    <= word_cnt_d;
              timer_q       <= '0;
              state_q       <= ST_WAIT_OUT;
            end else if (idle_or_done) begin
              // Single-word message: start and end fused.
              kc_reset_q    <= 1'b1;
              kc_in_q       <= opa;
              kc_in_valid_q <= 1'b1;
              kc_is_last_q  <= 1'b1;
              word_cnt_q    <= CW'(1);
              timer_q       <= '0;
              state_q       <= ST_WAIT_OUT;
            end else begin
              err_q <= 1'b1;
            end
          end
          OP_STORE: begin
            if ((state_q != ST_DONE) || lane_oob) begin
              err_q <= 1'b1;
            end
          end
          default: begin
            err_q <= 1'b1;
          end
        endcase
      end
    end
  end

  keccak_lane_mux #(
    .OUT_WORDS (OUT_WORDS)
  ) u_lane_mux (
    .clk            (clk),
    .rst            (rst),
    .en_i           (store_en),
    .zero_i         (state_q != ST_DONE),
    .lane_i         (cust5_limm),
    .digest_i       (digest_q),
    .result_o       (result),
    .result_valid_o (result_valid)
  );

  assign kc_in       = kc_in_q;
  assign kc_in_valid = kc_in_valid_q;
  assign kc_is_last  = kc_is_last_q;
  assign kc_reset    = kc_reset_q;
  assign err         = err_q;

endmodule

// File: tb/tb_keccak_cust5_sequencer.sv
module tb_keccak_cust5_sequencer;
  import keccak_cust5_pkg::*;

  localparam int TIMEOUT = 1023;

  logic         clk = 1'b0;
  logic         rst, insn_valid, ex_freeze;
  logic [4:0]   cust5_op;
  logic [5:0]   cust5_limm;
  logic [31:0]  opa;
  logic [31:0]  kc_in;
  logic         kc_in_valid, kc_is_last, kc_reset;
  logic         kc_buffer_full, kc_out_ready;
  logic [511:0] kc_out;
  logic [31:0]  result;
  logic         result_valid, stall, err;

  always #5 clk = ~clk;

  keccak_cust5_sequencer #(
    .RATE_WORDS (34),
    .OUT_WORDS  (16),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .insn_valid     (insn_valid),
    .ex_freeze      (ex_freeze),
    .cust5_op       (cust5_op),
    .cust5_limm     (cust5_limm),
    .opa            (opa),
    .kc_in          (kc_in),
    .kc_in_valid    (kc_in_valid),
    .kc_is_last     (kc_is_last),
    .kc_reset       (kc_reset),
    .kc_buffer_full (kc_buffer_full),
    .kc_out_ready   (kc_out_ready),
    .kc_out         (kc_out),
    .result         (result),
    .result_valid   (result_valid),
    .stall          (stall),
    .err            (err)
  );

  int checks   = 0;
  int failures = 0;

  // Core-side event: reset pulse and/or word write.
  typedef struct packed {
    logic        r;
    logic        w;
    logic        l;
    logic [31:0] d;
  } ev_t;

  ev_t         got_ev[$];
  ev_t         exp_ev[$];
  logic [31:0] got_res[$];
  logic [31:0] exp_res[$];
  bit          mon_en = 1'b0;

  // Reference model: message phase, error flag, digest lanes.
  typedef enum int {PH_IDLE, PH_ABSORB, PH_WAIT, PH_DONE} phase_t;
  phase_t      m_phase = PH_IDLE;
  bit          m_err   = 1'b0;
  logic [31:0] m_dig[16];

  always @(negedge clk) begin
    if (mon_en) begin
      if (kc_reset || kc_in_valid)
        got_ev.push_back(ev_t'{kc_reset, kc_in_valid, kc_in_valid ? kc_is_last : 1'b0,
                               kc_in_valid ? kc_in : 32'd0});
      if (result_valid)
        got_res.push_back(result);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk_ev(input logic r, input logic w, input logic l, input logic [31:0] d);
    return ev_t'{r, w, l, d};
  endfunction

  task automatic model_op(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] a);
    case (op)
      OP_RESET: begin
        m_phase = PH_IDLE;
        m_err   = 1'b0;
        foreach (m_dig[i]) m_dig[i] = 32'd0;
        exp_ev.push_back(mk_ev(1'b1, 1'b0, 1'b0, 32'd0));
      end
      OP_START: begin
        if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
          exp_ev.push_back(mk_ev(1'b1, 1'b1, 1'b0, a));
          m_phase = PH_ABSORB;
        end else m_err = 1'b1;
      end
      OP_MIDDLE: begin
        if (m_phase == PH_ABSORB) exp_ev.push_back(mk_ev(1'b0, 1'b1, 1'b0, a));
        else m_err = 1'b1;
      end
      OP_END: begin
        if (m_phase == PH_ABSORB) begin
          exp_ev.push_back(mk_ev(1'b0, 1'b1, 1'b1, a));
          m_phase = PH_WAIT;
        end else if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
          exp_ev.push_back(mk_ev(1'b1, 1'b1, 1'b1, a));
          m_phase = PH_WAIT;
        end else m_err = 1'b1;
      end
      OP_STORE: begin
        if (m_phase == PH_DONE && limm < 6'd16) begin
          exp_res.push_back(m_dig[limm[3:0]]);
        end else begin
          exp_res.push_back(32'd0);
          m_err = 1'b1;
        end
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic model_ready(input logic [511:0] d);
    if (m_phase == PH_WAIT) begin
      for (int i = 0; i < 16; i++) m_dig[i] = d[32*i +: 32];
      m_phase = PH_DONE;
    end
  endtask

  function automatic logic [511:0] rand_dig();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present an instruction and hold it until the DUT accepts it.
  task automatic issue(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] a,
                       output int waited);
    insn_valid = 1'b1;
    cust5_op   = op;
    cust5_limm = limm;
    opa        = a;
    waited     = 0;
    forever begin
      @(negedge clk);
      if (!stall && !ex_freeze) break;
      waited++;
      if (waited > 3000) begin
        check("issue_bound", 64'(waited), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    insn_valid = 1'b0;
  endtask

  task automatic pulse_ready(input logic [511:0] d);
    kc_out       = d;
    kc_out_ready = 1'b1;
    @(posedge clk);
    #1;
    kc_out_ready = 1'b0;
    model_ready(d);
  endtask

  task automatic cmp_queues(input string tag);
    check({tag, "_nev"}, 64'(got_ev.size()), 64'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      check({tag, "_ev"}, 64'(got_ev[i]), 64'(exp_ev[i]));
    check({tag, "_nres"}, 64'(got_res.size()), 64'(exp_res.size()));
    for (int i = 0; i < exp_res.size() && i < got_res.size(); i++)
      check({tag, "_res"}, 64'(got_res[i]), 64'(exp_res[i]));
    check({tag, "_err"}, 64'(err), 64'(m_err));
    got_ev.delete();
    exp_ev.delete();
    got_res.delete();
    exp_res.delete();
  endtask

  initial begin
    int          w, wsum, cyc, n;
    logic [31:0] a;
    logic [5:0]  l;
    logic [511:0] dg;

    foreach (m_dig[i]) m_dig[i] = 32'd0;
    rst = 1'b1; insn_valid = 1'b0; ex_freeze = 1'b0; cust5_op = 5'd0; cust5_limm = 6'd0;
    opa = 32'd0; kc_buffer_full = 1'b0; kc_out_ready = 1'b0; kc_out = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_kc_reset", 64'(kc_reset), 64'd1);
    check("rst_kc_in_valid", 64'(kc_in_valid), 64'd0);
    check("rst_kc_is_last", 64'(kc_is_last), 64'd0);
    check("rst_kc_in", 64'(kc_in), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    check("rst_kc_reset_drop", 64'(kc_reset), 64'd0);
    mon_en = 1'b1;

    // Message of words 1..7, digest 24 cycles after the last word.
    issue(OP_START, 6'd0, 32'd1, w); model_op(OP_START, 6'd0, 32'd1);
    for (int i = 2; i <= 6; i++) begin
      issue(OP_MIDDLE, 6'd0, 32'(i), w); model_op(OP_MIDDLE, 6'd0, 32'(i));
    end
    issue(OP_END, 6'd0, 32'd7, w); model_op(OP_END, 6'd0, 32'd7);
    idle(23);
    pulse_ready(rand_dig());
    idle(2);
    cmp_queues("msg7");

    // Back-to-back stores of every lane, then random lanes.
    wsum = 0;
    for (int i = 15; i >= 0; i--) begin
      issue(OP_STORE, 6'(i), $urandom, w); model_op(OP_STORE, 6'(i), 32'd0);
      wsum += w;
    end
    for (int i = 0; i < 8; i++) begin
      l = 6'($urandom_range(0, 15));
      issue(OP_STORE, l, $urandom, w); model_op(OP_STORE, l, 32'd0);
      wsum += w;
    end
    idle(2);
    check("store_stall_cycles", 64'(wsum), 64'd0);
    cmp_queues("stores");

    // Store presented during WAIT_OUT; digest arrives during the stall.
    n = $urandom_range(1, 5);
    a = $urandom; issue(OP_START, 6'd0, a, w); model_op(OP_START, 6'd0, a);
    for (int i = 0; i < n; i++) begin
      a = $urandom; issue(OP_MIDDLE, 6'd0, a, w); model_op(OP_MIDDLE, 6'd0, a);
    end
    a = $urandom; issue(OP_END, 6'd0, a, w); model_op(OP_END, 6'd0, a);
    dg = rand_dig();
    l  = 6'($urandom_range(0, 15));
    fork
      issue(OP_STORE, l, 32'd0, w);
      begin
        idle(4);
        pulse_ready(dg);
      end
    join
    model_op(OP_STORE, l, 32'd0);
    check("wait_store_stall", 64'(w), 64'd5);
    idle(2);
    cmp_queues("wait_store");

    // Buffer full for 3 cycles during a middle word, then EX freeze for 2.
    a = $urandom; issue(OP_START, 6'd0, a, w); model_op(OP_START, 6'd0, a);
    kc_buffer_full = 1'b1;
    a = $urandom;
    fork
      issue(OP_MIDDLE, 6'd0, a, w);
      begin
        idle(3);
        kc_buffer_full = 1'b0;
      end
    join
    model_op(OP_MIDDLE, 6'd0, a);
    check("full_stall", 64'(w), 64'd3);
    ex_freeze = 1'b1;
    a = $urandom;
    fork
      issue(OP_MIDDLE, 6'd0, a, w);
      begin
        idle(2);
        ex_freeze = 1'b0;
      end
    join
    model_op(OP_MIDDLE, 6'd0, a);
    check("freeze_wait", 64'(w), 64'd2);
    idle(2);
    cmp_queues("full");

    // Reset sub-op after 3 absorbed words, then a long message past the rate.
    issue(OP_RESET, 6'd0, 32'd0, w); model_op(OP_RESET, 6'd0, 32'd0);
    a = $urandom; issue(OP_START, 6'd0, a, w); model_op(OP_START, 6'd0, a);
    wsum = 0;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; issue(OP_MIDDLE, 6'd0, a, w); model_op(OP_MIDDLE, 6'd0, a);
      wsum += w;
    end
    check("long_msg_stall", 64'(wsum), 64'd0);
    a = $urandom; issue(OP_END, 6'd0, a, w); model_op(OP_END, 6'd0, a);
    idle($urandom_range(1, 30));
    pulse_ready(rand_dig());
    l = 6'($urandom_range(0, 15));
    issue(OP_STORE, l, 32'd0, w); model_op(OP_STORE, l, 32'd0);
    idle(2);
    cmp_queues("reset_long");

    // Illegal sequences.
    issue(OP_RESET, 6'd0, 32'd0, w); model_op(OP_RESET, 6'd0, 32'd0);
    a = $urandom; issue(OP_MIDDLE, 6'd0, a, w); model_op(OP_MIDDLE, 6'd0, a);
    idle(2);
    cmp_queues("mid_in_idle");
    issue(OP_STORE, 6'd2, 32'd0, w); model_op(OP_STORE, 6'd2, 32'd0);
    issue(5'b10000, 6'd0, 32'd0, w); model_op(5'b10000, 6'd0, 32'd0);
    idle(2);
    cmp_queues("store_idle_undef");
    issue(OP_RESET, 6'd0, 32'd0, w); model_op(OP_RESET, 6'd0, 32'd0);
    idle(1);
    check("err_cleared", 64'(err), 64'd0);
    a = $urandom; issue(OP_END, 6'd0, a, w); model_op(OP_END, 6'd0, a);
    idle(3);
    pulse_ready(rand_dig());
    issue(OP_STORE, 6'b010000, 32'd0, w); model_op(OP_STORE, 6'b010000, 32'd0);
    issue(OP_STORE, 6'd3, 32'd0, w); model_op(OP_STORE, 6'd3, 32'd0);
    a = $urandom; issue(OP_START, 6'd0, a, w); model_op(OP_START, 6'd0, a);
    a = $urandom; issue(OP_START, 6'd0, a, w); model_op(OP_START, 6'd0, a);
    idle(2);
    cmp_queues("oob_start2");

    // Timeout: digest never arrives.
    issue(OP_RESET, 6'd0, 32'd0, w); model_op(OP_RESET, 6'd0, 32'd0);
    a = $urandom; issue(OP_START, 6'd0, a, w); model_op(OP_START, 6'd0, a);
    a = $urandom; issue(OP_END, 6'd0, a, w); model_op(OP_END, 6'd0, a);
    cyc = 0;
    while (!err && cyc < TIMEOUT + 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("timeout_cycles", 64'(cyc), 64'(TIMEOUT));
    m_phase = PH_IDLE;
    m_err   = 1'b1;
    issue(OP_STORE, 6'd1, 32'd0, w); model_op(OP_STORE, 6'd1, 32'd0);
    check("timeout_idle_nostall", 64'(w), 64'd0);
    idle(2);
    cmp_queues("timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
